// File: rtl/field_extract_if.sv
// Packet-in / field-out stream bundle for field_extract.
// The "slave" modport is the extractor's view; "master" is the source/sink side.
interface field_extract_if #(
  parameter int DATA_WIDTH = 32,
  parameter int FIELD_SIZE = 16
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_sop;
  logic                  in_eop;
  logic                  in_ready;
  logic [FIELD_SIZE-1:0] field;
  logic                  valid;
  logic                  clear;
  logic                  ready;

  modport master (
    output in_data, in_valid, in_sop, in_eop, ready,
    input  in_ready, field, valid, clear
  );

  modport slave (
    input  in_data, in_valid, in_sop, in_eop, ready,
    output in_ready, field, valid, clear
  );
endinterface

// File: rtl/field_extract.sv
// Pulls a 2-byte big-endian field at a byte offset out of each packet and
// emits it with a per-window clear flag; packets ending early are counted.
module field_extract #(
  parameter int DATA_WIDTH = 32,
  parameter int FIELD_SIZE = 16
) (
  input  logic              sys_clk,
  input  logic              reset_n,
  field_extract_if.slave    bus,
  input  logic [15:0]       offset,
  input  logic [15:0]       window,
  output logic [15:0]       short_cnt
);
  typedef enum logic [1:0] {IDLE, SCAN, SPLIT, DRAIN} state_t;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {15'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  state_t                r_state, w_state_nxt;
  logic [15:0]           r_off, r_wcnt, r_win_cnt, r_short;
  logic [7:0]            r_msb;
  logic [FIELD_SIZE-1:0] r_field_p1;
  logic                  r_vld_p1, r_clr_p1;

  logic        w_acc, w_scan, w_cap, w_msb_ld, w_off_ld, w_clr_nxt;
  logic [15:0] w_off_eff, w_idx, w_k, w_wcnt_nxt, w_cap_data, w_win_eff, w_win_nxt;
  logic [1:0]  w_lane, w_short_inc;
  logic [7:0]  w_b0, w_b1, w_b2, w_b3;

  assign w_b0 = bus.in_data[DATA_WIDTH-1  -: 8];
  assign w_b1 = bus.in_data[DATA_WIDTH-9  -: 8];
  assign w_b2 = bus.in_data[DATA_WIDTH-17 -: 8];
  assign w_b3 = bus.in_data[DATA_WIDTH-25 -: 8];

  // A held sample blocks input so the word that would overwrite it is never taken.
  assign bus.in_ready = !(r_vld_p1 && !bus.ready);
  assign w_acc        = bus.in_valid && bus.in_ready;

  // An accepted sop is processed as word 0 with the live offset in any state.
  assign w_off_eff = bus.in_sop ? offset : r_off;
  assign w_idx     = bus.in_sop ? 16'd0 : r_wcnt;
  assign w_k       = {2'b00, w_off_eff[15:2]};
  assign w_lane    = w_off_eff[1:0];
  assign w_scan    = w_acc && (bus.in_sop || r_state == SCAN);

  always_comb begin
    w_state_nxt = r_state;
    w_cap       = 1'b0;
    w_cap_data  = 16'd0;
    w_msb_ld    = 1'b0;
    w_off_ld    = 1'b0;
    w_wcnt_nxt  = r_wcnt;
    w_short_inc = 2'd0;
    if (w_acc && bus.in_sop) begin
      w_off_ld = 1'b1;
      if (r_state == SCAN || r_state == SPLIT) w_short_inc = 2'd1;
    end
    if (w_scan) begin
      if (w_idx == w_k) begin
        if (w_lane != 2'd3) begin
          w_cap = 1'b1;
          case (w_lane)
            2'd0:    w_cap_data = {w_b0, w_b1};
            2'd1:    w_cap_data = {w_b1, w_b2};
            default: w_cap_data = {w_b2, w_b3};
          endcase
          w_state_nxt = bus.in_eop ? IDLE : DRAIN;
        end else if (bus.in_eop) begin
          w_short_inc = w_short_inc + 2'd1;
          w_state_nxt = IDLE;
        end else begin
          w_msb_ld    = 1'b1;
          w_state_nxt = SPLIT;
        end
      end else if (bus.in_eop) begin
        w_short_inc = w_short_inc + 2'd1;
        w_state_nxt = IDLE;
      end else begin
        w_wcnt_nxt  = sat_add16(w_idx, 2'd1);
        w_state_nxt = SCAN;
      end
    end else if (w_acc) begin
      case (r_state)
        SPLIT: begin
          w_cap       = 1'b1;
          w_cap_data  = {r_msb, w_b0};
          w_state_nxt = bus.in_eop ? IDLE : DRAIN;
        end
        DRAIN:   if (bus.in_eop) w_state_nxt = IDLE;
        default: ;
      endcase
    end
  end

  // A stale counter at or above a shrunken window restarts the window.
  assign w_win_eff = (r_win_cnt >= window) ? 16'd0 : r_win_cnt;
  assign w_clr_nxt = (window != 16'd0) && (w_win_eff == 16'd0);
  assign w_win_nxt = ((w_win_eff + 16'd1) >= window) ? 16'd0 : (w_win_eff + 16'd1);

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // ---- capture stage -> output register (p1) ----
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_off      <= 16'd0;
      r_wcnt     <= 16'd0;
      r_win_cnt  <= 16'd0;
      r_short    <= 16'd0;
      r_field_p1 <= '0;
      r_vld_p1   <= 1'b0;
      r_clr_p1   <= 1'b0;
    end else begin
      if (w_off_ld) r_off <= offset;
      r_wcnt  <= w_wcnt_nxt;
      r_short <= sat_add16(r_short, w_short_inc);
      if (w_cap) begin
        r_field_p1 <= FIELD_SIZE'(w_cap_data);
        r_vld_p1   <= 1'b1;
        r_clr_p1   <= w_clr_nxt;
        r_win_cnt  <= w_win_nxt;
      end else if (r_vld_p1 && bus.ready) begin
        r_vld_p1 <= 1'b0;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (w_msb_ld) r_msb <= w_b3;
  end

  assign bus.field = r_field_p1;
  assign bus.valid = r_vld_p1;
  assign bus.clear = r_clr_p1;
  assign short_cnt = r_short;
endmodule

// File: tb/tb_field_extract.sv
// Self-checking bench for field_extract: directed sequences, a vector table,
// and randomized packets scored against a byte-level packet model.
module tb_field_extract;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] offset, window, short_cnt;

  field_extract_if bus ();

  field_extract dut (
    .sys_clk  (clk),
    .reset_n  (rst_n),
    .bus      (bus),
    .offset   (offset),
    .window   (window),
    .short_cnt(short_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0]  off;
    logic [127:0] words;
    logic [2:0]   nw;
    logic         ev;
    logic [15:0]  ef;
  } tv_t;

  typedef struct packed {
    logic [15:0] f;
    logic        c;
  } exp_t;

  int           checks = 0;
  int           errors = 0;
  tv_t          tv [11];
  exp_t         exp_q [$];
  int           nv, tshort, win_cnt, exp_short;
  logic [15:0]  lastf;
  logic [127:0] ws;
  int           wins [5];
  bit           drv_done;

  function automatic tv_t mk(input logic [15:0] off, input logic [127:0] w, input logic [2:0] n,
                             input logic ev, input logic [15:0] ef);
    tv_t r;
    r.off = off; r.words = w; r.nw = n; r.ev = ev; r.ef = ef;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called 1 time unit after a rising edge; returns 1 unit after the accepting edge.
  task automatic send_word(input logic [31:0] d, input logic s, input logic e);
    logic ok;
    bus.in_data = d; bus.in_sop = s; bus.in_eop = e; bus.in_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 500 && !ok; t++) begin
      #1;
      ok = bus.in_ready;
      @(posedge clk);
      #1;
    end
    chk("word_accepted", 32'(ok), 32'd1);
    bus.in_valid = 1'b0; bus.in_sop = 1'b0; bus.in_eop = 1'b0;
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0; bus.in_sop = 1'b0; bus.in_eop = 1'b0;
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
  endtask

  initial begin
    rst_n = 1'b1;
    bus.in_data = '0; bus.in_valid = 1'b0; bus.in_sop = 1'b0; bus.in_eop = 1'b0;
    bus.ready = 1'b1; offset = 16'd0; window = 16'd0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(bus.valid), 32'd0);
    chk("rst_clear", 32'(bus.clear), 32'd0);
    chk("rst_field", 32'(bus.field), 32'd0);
    chk("rst_short", 32'(short_cnt), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);

    // Eight packets, field in bytes 2..3 of word 0, window of 4.
    window = 16'd4; offset = 16'd2;
    for (int p = 0; p < 8; p++) begin
      send_word({16'($urandom_range(0, 65535)), 16'h1234}, 1'b1, 1'b0);
      chk($sformatf("p%0d_valid", p), 32'(bus.valid), 32'd1);
      chk($sformatf("p%0d_field", p), 32'(bus.field), 32'h1234);
      chk($sformatf("p%0d_clear", p), 32'(bus.clear), 32'((p % 4) == 0));
      for (int w = 1; w < 4; w++) begin
        send_word($urandom, 1'b0, w == 3);
        chk($sformatf("p%0d_w%0d_novalid", p, w), 32'(bus.valid), 32'd0);
      end
    end

    // Field straddling words 1 and 2.
    offset = 16'd7;
    send_word($urandom, 1'b1, 1'b0);
    send_word(32'h000000AB, 1'b0, 1'b0);
    chk("split_early", 32'(bus.valid), 32'd0);
    send_word(32'hCD000000, 1'b0, 1'b0);
    chk("split_valid", 32'(bus.valid), 32'd1);
    chk("split_field", 32'(bus.field), 32'hABCD);
    chk("split_clear", 32'(bus.clear), 32'd1);
    send_word($urandom, 1'b0, 1'b1);

    // Offset past a 2-word packet, then a good one.
    window = 16'd0; offset = 16'd12;
    send_word($urandom, 1'b1, 1'b0);
    send_word($urandom, 1'b0, 1'b1);
    chk("short_novalid", 32'(bus.valid), 32'd0);
    chk("short_cnt1", 32'(short_cnt), 32'd1);
    offset = 16'd0;
    send_word(32'hBEEF0000, 1'b1, 1'b0);
    chk("beef_valid", 32'(bus.valid), 32'd1);
    chk("beef_field", 32'(bus.field), 32'hBEEF);
    send_word($urandom, 1'b0, 1'b1);
    chk("beef_short", 32'(short_cnt), 32'd1);

    // Downstream stall while the next packet's sop waits.
    bus.ready = 1'b0;
    send_word(32'h5A5A0000, 1'b1, 1'b1);
    bus.in_data = 32'h11111111; bus.in_sop = 1'b1; bus.in_eop = 1'b0; bus.in_valid = 1'b1;
    offset = 16'd4;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("stall%0d_in_ready", c), 32'(bus.in_ready), 32'd0);
      chk($sformatf("stall%0d_field", c), 32'(bus.field), 32'h5A5A);
      chk($sformatf("stall%0d_valid", c), 32'(bus.valid), 32'd1);
      @(posedge clk); #1;
    end
    bus.ready = 1'b1;
    send_word(32'h11111111, 1'b1, 1'b0);
    chk("stall_consumed", 32'(bus.valid), 32'd0);
    send_word(32'h22220000, 1'b0, 1'b1);
    chk("stall_next_valid", 32'(bus.valid), 32'd1);
    chk("stall_next_field", 32'(bus.field), 32'h2222);

    // Reset while waiting for the LSB of a split field.
    window = 16'd4; offset = 16'd3;
    send_word(32'h000000AB, 1'b1, 1'b0);
    chk("pre_rst_valid", 32'(bus.valid), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(bus.valid), 32'd0);
    chk("midrst_short", 32'(short_cnt), 32'd0);
    chk("midrst_field", 32'(bus.field), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    send_word(32'hCD110000, 1'b0, 1'b1);
    chk("postrst_stray", 32'(bus.valid), 32'd0);
    send_word(32'h000000AB, 1'b1, 1'b0);
    send_word(32'hCD000000, 1'b0, 1'b0);
    chk("postrst_valid", 32'(bus.valid), 32'd1);
    chk("postrst_field", 32'(bus.field), 32'hABCD);
    chk("postrst_clear", 32'(bus.clear), 32'd1);
    send_word($urandom, 1'b0, 1'b1);
    chk("postrst_short", 32'(short_cnt), 32'd0);

    // Restart by a second sop before the first packet captured.
    window = 16'd0; offset = 16'd8;
    send_word($urandom, 1'b1, 1'b0);
    send_word($urandom, 1'b0, 1'b0);
    offset = 16'd1;
    send_word(32'h00C0FFEE, 1'b1, 1'b0);
    chk("restart_valid", 32'(bus.valid), 32'd1);
    chk("restart_field", 32'(bus.field), 32'hC0FF);
    chk("restart_short", 32'(short_cnt), 32'd1);
    send_word($urandom, 1'b0, 1'b1);

    // Lane/length corner vectors (ready held high, window off).
    tv[0]  = mk(16'd0,   {32'hA1B2C3D4, 96'h0}, 3'd1, 1'b1, 16'hA1B2);
    tv[1]  = mk(16'd1,   {32'hA1B2C3D4, 96'h0}, 3'd1, 1'b1, 16'hB2C3);
    tv[2]  = mk(16'd2,   {32'hA1B2C3D4, 96'h0}, 3'd1, 1'b1, 16'hC3D4);
    tv[3]  = mk(16'd3,   {32'hA1B2C3D4, 96'h0}, 3'd1, 1'b0, 16'h0);
    tv[4]  = mk(16'd3,   {32'hA1B2C3D4, 32'hE5F60708, 64'h0}, 3'd2, 1'b1, 16'hD4E5);
    tv[5]  = mk(16'd4,   {32'hA1B2C3D4, 96'h0}, 3'd1, 1'b0, 16'h0);
    tv[6]  = mk(16'd5,   {32'h0, 32'h11223344, 64'h0}, 3'd2, 1'b1, 16'h2233);
    tv[7]  = mk(16'd15,  {32'h0, 32'h0, 32'h0, 32'h000000FF}, 3'd4, 1'b0, 16'h0);
    tv[8]  = mk(16'd14,  {32'h0, 32'h0, 32'h0, 32'h0000FEDC}, 3'd4, 1'b1, 16'hFEDC);
    tv[9]  = mk(16'd100, {32'h1, 32'h2, 32'h3, 32'h0}, 3'd3, 1'b0, 16'h0);
    tv[10] = mk(16'd11,  {32'h0, 32'h0, 32'h0000009A, 32'hBC000000}, 3'd4, 1'b1, 16'h9ABC);
    tshort = 1;
    for (int i = 0; i < 11; i++) begin
      offset = tv[i].off;
      ws = tv[i].words;
      nv = 0; lastf = 16'd0;
      for (int w = 0; w < int'(tv[i].nw); w++) begin
        send_word(ws[127-32*w -: 32], w == 0, w == int'(tv[i].nw) - 1);
        if (bus.valid) begin
          nv++;
          lastf = bus.field;
        end
      end
      if (!tv[i].ev) tshort++;
      chk($sformatf("tbl%0d_nvalid", i), 32'(nv), 32'(tv[i].ev));
      if (tv[i].ev) chk($sformatf("tbl%0d_field", i), 32'(lastf), 32'(tv[i].ef));
      chk($sformatf("tbl%0d_short", i), 32'(short_cnt), 32'(tshort));
    end

    // Randomized packets against the byte-level model.
    do_reset();
    exp_short = 0; win_cnt = 0;
    wins[0] = 5; wins[1] = 2; wins[2] = 0; wins[3] = 1; wins[4] = 3;
    for (int seg = 0; seg < 5; seg++) begin
      window = 16'(wins[seg]);
      drv_done = 1'b0;
      fork
        begin
          int len, off, t;
          logic [7:0] pb [24];
          exp_t e;
          for (int p = 0; p < 40; p++) begin
            len = int'($urandom_range(1, 6));
            off = int'($urandom_range(0, 4 * len + 3));
            for (int b = 0; b < 4 * len; b++) pb[b] = 8'($urandom);
            t = len;
            if (p < 39 && len > 1 && $urandom_range(0, 4) == 0) t = int'($urandom_range(1, len - 1));
            if (off + 1 <= 4 * t - 1) begin
              e.f = {pb[off], pb[off+1]};
              if (wins[seg] == 0) begin
                e.c = 1'b0;
                win_cnt = 0;
              end else begin
                if (win_cnt >= wins[seg]) win_cnt = 0;
                e.c = (win_cnt == 0);
                win_cnt = (win_cnt + 1) % wins[seg];
              end
              exp_q.push_back(e);
            end else begin
              exp_short++;
            end
            offset = 16'(off);
            for (int w = 0; w < t; w++) begin
              if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
              send_word({pb[4*w], pb[4*w+1], pb[4*w+2], pb[4*w+3]}, w == 0, (w == t - 1) && (t == len));
            end
          end
          drv_done = 1'b1;
        end
        begin
          exp_t m;
          int guard;
          guard = 0;
          while (!(drv_done && exp_q.size() == 0) && guard < 5000) begin
            @(negedge clk);
            guard++;
            chk("in_ready_rule", 32'(bus.in_ready), 32'(!(bus.valid && !bus.ready)));
            if (bus.valid && bus.ready) begin
              if (exp_q.size() == 0) begin
                chk("rnd_unexpected_valid", 32'(bus.valid), 32'd0);
              end else begin
                m = exp_q.pop_front();
                chk("rnd_field", 32'(bus.field), 32'(m.f));
                chk("rnd_clear", 32'(bus.clear), 32'(m.c));
              end
            end
            @(posedge clk); #1;
            bus.ready = ($urandom_range(0, 3) != 0);
          end
          chk("rnd_drained", 32'(guard < 5000), 32'd1);
        end
      join
      chk($sformatf("rnd_seg%0d_tail_valid", seg), 32'(bus.valid), 32'd0);
      chk($sformatf("rnd_seg%0d_short", seg), 32'(short_cnt), 32'(exp_short));
      bus.ready = 1'b1;
      exp_q.delete();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/field_extract.md
FIELD_EXTRACT -- requirements
Module: field_extract

Interface
REQ-001 Parameter DATA_WIDTH, default 32: input stream word width, fixed at 32 in this revision.
REQ-002 Parameter FIELD_SIZE, default 16: width of the extracted field.
REQ-003 sys_clk  in  1  single clock; all logic is rising-edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 in_data  in  32  packet word; big-endian, byte 0 = in_data[31:24].
REQ-006 in_valid / in_sop / in_eop  in  1 each  word valid, first word, last word.
REQ-007 in_ready  out  1  block accepts the word this cycle.
REQ-008 offset  in  16  byte offset of field from packet start; latched on accepted sop.
REQ-009 window  in  16  fields per clear window; 0 = clear never asserted.
REQ-010 field  out  FIELD_SIZE  extracted field, feeds repetition stage.
REQ-011 valid  out  1  field/clear hold a new sample.
REQ-012 clear  out  1  first field of a new window.
REQ-013 ready  in  1  downstream accepts the sample.
REQ-014 short_cnt  out  16  packets ended before the field was complete.

Function
REQ-015 A word is accepted when in_valid && in_ready.
REQ-016 in_ready SHALL be 1 unless valid=1 && ready=0.
REQ-017 Field position: word index k = offset>>2, lane = offset[1:0]; lane 0..2 takes bytes lane, lane+1 of word k; lane 3 takes byte 3 of word k as the MSB and byte 0 of word k+1 as the LSB.
REQ-018 FSM states:
  - IDLE: wait for sop.
  - SCAN: count words.
  - SPLIT: MSB held, waiting for word k+1.
  - DRAIN: field done, discard until eop.
REQ-019 IDLE->SCAN on accepted sop; the word counter is 0 on the sop word.
REQ-020 Capture is done in the cycle of the accepted word that completes the field.
  - The state moves to DRAIN, or to IDLE if that word has eop.
  - lane 3 on word k moves to SPLIT instead.
REQ-021 valid SHALL rise the cycle after capture; field/clear hold stable while valid && !ready; the sample is consumed on valid && ready.
REQ-022 Back-to-back capture on the consume cycle SHALL reload the register with valid held at 1.
REQ-023 If eop arrives before capture, the packet is dropped.
  - No valid is produced.
  - short_cnt increments by 1, saturating at 16'hFFFF.
  - State returns to IDLE.
REQ-024 An accepted sop in SCAN/SPLIT/DRAIN restarts the packet.
  - The old packet counts as short if it was not captured.
  - offset is re-latched.
REQ-025 A word with sop and eop together is a one-word packet; only lane 0..2 with k=0 can capture.
REQ-026 Word counter is 16 bits and saturates; offsets beyond the packet give a short packet.
REQ-027 Window counter counts emitted fields, 0..window-1, wrapping to 0.
  - clear=1 on a field emitted while the counter is 0 and window!=0.
  - The first field after reset has clear=1 when window!=0.
REQ-028 A change to window takes effect at the next emission; a counter value >= window forces a wrap to 0 with clear=1.
REQ-029 Words with in_valid=0 SHALL not change state or counters.

Reset
REQ-030 reset_n low SHALL immediately set:
  - state to IDLE;
  - valid=0, clear=0, field=0;
  - short_cnt=0, word and window counters to 0;
  - in_ready=1.
REQ-031 Reset mid-packet discards the packet without counting it as short; after release the block waits for a fresh sop.

Verification
REQ-032 offset=2, window=4, eight 4-word packets with bytes 2..3 = 0x1234, ready=1 -> eight valid pulses, field=0x1234, clear=1 on samples 1 and 5, 1-cycle latency after word 0.
REQ-033 offset=7, word1=0x000000AB, word2=0xCD000000 -> field=0xABCD, valid the cycle after word2 is accepted.
REQ-034 offset=12, 2-word packet -> no valid, short_cnt=1; next packet with offset=0 and word0=0xBEEF0000 -> field=0xBEEF.
REQ-035 ready=0 for 5 cycles after valid -> field held, in_ready=0 throughout, no word lost; the stream resumes once ready returns.
REQ-036 Assert reset_n low while in SPLIT -> valid=0, short_cnt=0; the next full packet extracts correctly with clear=1.
REQ-037 Second sop arrives before capture of the first packet -> short_cnt=1 and the second packet's field is emitted.
